// File: rtl/alu_ctrl_mc_if.sv
// Bundle between the EX-stage decode inputs and the ALU / HI-LO unit outputs
// of alu_ctrl_mc. The master side is the pipeline (it drives the decode
// inputs); the slave side is the ALU control block itself.
interface alu_ctrl_mc_if #(
    parameter int ALUOP_W = 3
);
    logic               valid_i;
    logic               flush_i;
    logic [5:0]         funct_i;
    logic [ALUOP_W-1:0] aluop_i;
    logic [3:0]         aluctrl_o;
    logic               sign_extend_o;
    logic               illegal_o;
    logic [1:0]         hilo_rd_o;
    logic               md_start_o;
    logic [1:0]         md_op_o;
    logic               busy_o;
    logic               hilo_we_o;
    logic               stall_o;

    modport master (
        output valid_i, flush_i, funct_i, aluop_i,
        input  aluctrl_o, sign_extend_o, illegal_o, hilo_rd_o,
        input  md_start_o, md_op_o, busy_o, hilo_we_o, stall_o
    );

    modport slave (
        input  valid_i, flush_i, funct_i, aluop_i,
        output aluctrl_o, sign_extend_o, illegal_o, hilo_rd_o,
        output md_start_o, md_op_o, busy_o, hilo_we_o, stall_o
    );
endinterface

// File: rtl/alu_ctrl_mc.sv
// EX-stage ALU control: combinational ALUOp/funct decode plus a multi-cycle
// sequencer that launches MULT/MULTU/DIV/DIVU on the HI/LO unit, counts
// their latency and stalls the pipeline on HI/LO hazards.
module alu_ctrl_mc #(
    parameter int ALUOP_W = 3,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic         clk_i,
    input  logic         rst_i,
    alu_ctrl_mc_if.slave bus
);
    // ALU operation codes
    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_NAND  = 4'd2;
    localparam logic [3:0] OP_NOR   = 4'd3;
    localparam logic [3:0] OP_ADDU  = 4'd4;
    localparam logic [3:0] OP_SUBU  = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_EQUAL = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SRAV  = 4'd9;
    localparam logic [3:0] OP_LUI   = 4'd10;
    localparam logic [3:0] OP_SLTU  = 4'd11;
    localparam logic [3:0] OP_SLL   = 4'd12;
    localparam logic [3:0] OP_SRL   = 4'd13;
    localparam logic [3:0] OP_XOR   = 4'd14;

    // R-type funct encodings
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    // Counter preload values: the op stays in BUSY for LAT cycles
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             md_start_reg;
    logic [1:0]       md_op_reg;
    logic             hilo_we_reg;

    logic [3:0] aluctrl;
    logic       sign_extend;
    logic       illegal;
    logic [1:0] hilo_rd;
    logic       is_md;
    logic [1:0] md_code;
    logic       busy;
    logic       live;
    logic       accept;

    // Decode ALUOp/funct into ALU code, extend select and HI/LO op class
    always_comb begin
        aluctrl     = OP_ADDU;
        sign_extend = 1'b0;
        illegal     = 1'b0;
        hilo_rd     = 2'b00;
        is_md       = 1'b0;
        md_code     = 2'b00;
        if (bus.aluop_i == ALUOP_W'(0)) begin
            case (bus.funct_i)
                FN_ADDU:  aluctrl = OP_ADDU;
                FN_SUBU:  aluctrl = OP_SUBU;
                FN_AND:   aluctrl = OP_AND;
                FN_OR:    aluctrl = OP_OR;
                FN_XOR:   aluctrl = OP_XOR;
                FN_NOR:   aluctrl = OP_NOR;
                FN_SLT:   aluctrl = OP_SLT;
                FN_SLTU:  aluctrl = OP_SLTU;
                FN_SLL:   aluctrl = OP_SLL;
                FN_SRL:   aluctrl = OP_SRL;
                FN_SRA:   aluctrl = OP_SRA;
                FN_SRAV:  aluctrl = OP_SRAV;
                FN_MFHI:  hilo_rd = 2'b10;
                FN_MFLO:  hilo_rd = 2'b01;
                FN_MULT:  begin is_md = 1'b1; md_code = 2'b00; end
                FN_MULTU: begin is_md = 1'b1; md_code = 2'b01; end
                FN_DIV:   begin is_md = 1'b1; md_code = 2'b10; end
                FN_DIVU:  begin is_md = 1'b1; md_code = 2'b11; end
                default:  illegal = bus.valid_i;
            endcase
        end else begin
            case (bus.aluop_i)
                ALUOP_W'(1): begin aluctrl = OP_ADDU; sign_extend = 1'b1; end
                ALUOP_W'(2): begin aluctrl = OP_SLTU; sign_extend = 1'b1; end
                ALUOP_W'(3): begin aluctrl = OP_SUBU; sign_extend = 1'b1; end
                ALUOP_W'(4): begin aluctrl = OP_LUI;  sign_extend = 1'b0; end
                ALUOP_W'(5): begin aluctrl = OP_OR;   sign_extend = 1'b0; end
                ALUOP_W'(6): begin aluctrl = OP_SUBU; sign_extend = 1'b1; end
                ALUOP_W'(7): begin aluctrl = OP_AND;  sign_extend = 1'b0; end
                default:     begin aluctrl = OP_ADDU; sign_extend = 1'b0; end
            endcase
        end
    end

    // A live instruction is one that is valid and not being killed this cycle;
    // only live HI/LO instructions can stall or start the sequencer.
    assign busy   = (state_reg != IDLE);
    assign live   = bus.valid_i & ~bus.flush_i;
    assign accept = live & is_md & (state_reg == IDLE);

    // Multi-cycle sequencer: IDLE -> BUSY (LAT cycles) -> DONE (write HI/LO)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            md_start_reg <= 1'b0;
            md_op_reg    <= 2'b00;
            hilo_we_reg  <= 1'b0;
        end else begin
            md_start_reg <= 1'b0;
            hilo_we_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg    <= BUSY;
                        cnt_reg      <= md_code[1] ? DIV_CNT : MUL_CNT;
                        md_op_reg    <= md_code;
                        md_start_reg <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_reg == '0) begin
                        state_reg   <= DONE;
                        hilo_we_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // The hazard depends on the instruction class, not on ALUOp validity of
    // unrelated fields, so non-HI/LO traffic flows freely while busy.
    assign bus.stall_o       = live & (is_md | (hilo_rd != 2'b00)) & busy;
    assign bus.aluctrl_o     = aluctrl;
    assign bus.sign_extend_o = sign_extend;
    assign bus.illegal_o     = illegal;
    assign bus.hilo_rd_o     = hilo_rd;
    assign bus.md_start_o    = md_start_reg;
    assign bus.md_op_o       = md_op_reg;
    assign bus.busy_o        = busy;
    assign bus.hilo_we_o     = hilo_we_reg;
endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Directed bench for alu_ctrl_mc: decode tables, MD sequencer timing,
// HI/LO hazard stalls, async reset mid-op and flush.
module tb_alu_ctrl_mc;
    logic clk;
    logic rst;
    int   total_cnt;
    int   bad_cnt;

    alu_ctrl_mc_if #(.ALUOP_W(3)) bus ();

    alu_ctrl_mc #(
        .ALUOP_W(3),
        .MUL_LAT(4),
        .DIV_LAT(32),
        .CNT_W  (6)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_ADDU  = 6'b100001;

    // Expected decode tables, written out by hand
    logic [5:0] fn_tab   [12] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101,
                                  6'b100110, 6'b100111, 6'b101010, 6'b101011,
                                  6'b000000, 6'b000010, 6'b000011, 6'b000111};
    logic [3:0] fcode_tab[12] = '{4'd4, 4'd5, 4'd0, 4'd1, 4'd14, 4'd3,
                                  4'd6, 4'd11, 4'd12, 4'd13, 4'd8, 4'd9};
    logic [3:0] acode_tab[8]  = '{4'd0, 4'd4, 4'd11, 4'd5, 4'd10, 4'd1, 4'd5, 4'd0};
    logic       aext_tab [8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] fn, input logic [2:0] op, input logic fl);
        bus.valid_i = v;
        bus.funct_i = fn;
        bus.aluop_i = op;
        bus.flush_i = fl;
        #1;
    endtask

    int hwe_seen;

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst = 1'b1;
        drive(1'b0, 6'd0, 3'd0, 1'b0);

        // Reset state
        step();
        step();
        check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("rst_start", {31'd0, bus.md_start_o}, 32'd0);
        check("rst_we", {31'd0, bus.hilo_we_o}, 32'd0);
        check("rst_op", {30'd0, bus.md_op_o}, 32'd0);
        rst = 1'b0;

        // Decode sweep: ALUOp 1..7
        for (int a = 1; a < 8; a++) begin
            drive(1'b0, 6'd0, 3'(a), 1'b0);
            check($sformatf("aluop%0d_code", a), {28'd0, bus.aluctrl_o}, {28'd0, acode_tab[a]});
            check($sformatf("aluop%0d_ext", a), {31'd0, bus.sign_extend_o}, {31'd0, aext_tab[a]});
            $display("txn decode aluop=%0d code=%0d ext=%0d", a, bus.aluctrl_o, bus.sign_extend_o);
        end
        // Decode sweep: R-type funct table (valid asserted, all legal)
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, fn_tab[i], 3'd0, 1'b0);
            check($sformatf("fn%02h_code", fn_tab[i]), {28'd0, bus.aluctrl_o}, {28'd0, fcode_tab[i]});
            check($sformatf("fn%02h_ext", fn_tab[i]), {31'd0, bus.sign_extend_o}, 32'd0);
            check($sformatf("fn%02h_ill", fn_tab[i]), {31'd0, bus.illegal_o}, 32'd0);
            $display("txn decode funct=%06b code=%0d", fn_tab[i], bus.aluctrl_o);
        end
        drive(1'b1, 6'b111111, 3'd0, 1'b0);
        check("undef_code", {28'd0, bus.aluctrl_o}, 32'd4);
        check("undef_ill", {31'd0, bus.illegal_o}, 32'd1);
        drive(1'b0, 6'b111111, 3'd0, 1'b0);
        check("undef_ill_novalid", {31'd0, bus.illegal_o}, 32'd0);
        drive(1'b0, 6'b010000, 3'd0, 1'b0);
        check("mfhi_rd", {30'd0, bus.hilo_rd_o}, 32'd2);
        check("mfhi_code", {28'd0, bus.aluctrl_o}, 32'd4);
        drive(1'b0, F_DIV, 3'd0, 1'b0);
        check("div_code", {28'd0, bus.aluctrl_o}, 32'd4);
        $display("txn decode undefined/hilo done");

        // MULT: accept in cycle 0, start in 1, we in 5, idle in 6
        step();
        drive(1'b1, F_MULT, 3'd0, 1'b0);
        check("mult_c0_busy", {31'd0, bus.busy_o}, 32'd0);
        check("mult_c0_stall", {31'd0, bus.stall_o}, 32'd0);
        for (int c = 1; c <= 6; c++) begin
            step();
            drive(1'b0, 6'd0, 3'd0, 1'b0);
            check($sformatf("mult_c%0d_start", c), {31'd0, bus.md_start_o}, {31'd0, c == 1});
            check($sformatf("mult_c%0d_busy", c), {31'd0, bus.busy_o}, {31'd0, c <= 5});
            check($sformatf("mult_c%0d_we", c), {31'd0, bus.hilo_we_o}, {31'd0, c == 5});
            if (c == 1) check("mult_op", {30'd0, bus.md_op_o}, 32'd0);
        end
        $display("txn MULT latency sequence done");

        // DIVU then MFLO from cycle 2: stall 2..33, released in 34
        step();
        drive(1'b1, F_DIVU, 3'd0, 1'b0);
        step();
        drive(1'b0, 6'd0, 3'd0, 1'b0);
        check("divu_start", {31'd0, bus.md_start_o}, 32'd1);
        check("divu_op", {30'd0, bus.md_op_o}, 32'd3);
        for (int c = 2; c <= 34; c++) begin
            step();
            drive(1'b1, F_MFLO, 3'd0, 1'b0);
            check($sformatf("mflo_c%0d_stall", c), {31'd0, bus.stall_o}, {31'd0, c <= 33});
            if (c == 33) check("divu_we", {31'd0, bus.hilo_we_o}, 32'd1);
            if (c == 32) check("divu_we_early", {31'd0, bus.hilo_we_o}, 32'd0);
        end
        check("mflo_rd", {30'd0, bus.hilo_rd_o}, 32'd1);
        $display("txn DIVU + MFLO hazard done");

        // MULT in flight with ADDU every cycle: no stall, sequence intact
        step();
        drive(1'b1, F_MULT, 3'd0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            step();
            drive(1'b1, F_ADDU, 3'd0, 1'b0);
            check($sformatf("addu_c%0d_stall", c), {31'd0, bus.stall_o}, 32'd0);
            check($sformatf("addu_c%0d_code", c), {28'd0, bus.aluctrl_o}, 32'd4);
            check($sformatf("addu_c%0d_we", c), {31'd0, bus.hilo_we_o}, {31'd0, c == 5});
            check($sformatf("addu_c%0d_busy", c), {31'd0, bus.busy_o}, {31'd0, c <= 5});
        end
        $display("txn MULT + ADDU passthrough done");

        // MULT then DIV: DIV stalls 1..5, accepted in 6, start in 7
        step();
        drive(1'b1, F_MULT, 3'd0, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c <= 6) drive(1'b1, F_DIV, 3'd0, 1'b0);
            else        drive(1'b0, 6'd0, 3'd0, 1'b0);
            if (c <= 6) check($sformatf("div_c%0d_stall", c), {31'd0, bus.stall_o}, {31'd0, c <= 5});
            check($sformatf("div_c%0d_start", c), {31'd0, bus.md_start_o}, {31'd0, c == 1 || c == 7});
        end
        check("div_op", {30'd0, bus.md_op_o}, 32'd2);
        $display("txn MULT + DIV back-to-back done");

        // Async reset in cycle 3 of the DIV (accepted in cycle 6 above)
        step();
        step();
        check("pre_rst_busy", {31'd0, bus.busy_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("arst_op", {30'd0, bus.md_op_o}, 32'd0);
        check("arst_we", {31'd0, bus.hilo_we_o}, 32'd0);
        check("arst_start", {31'd0, bus.md_start_o}, 32'd0);
        step();
        rst = 1'b0;
        hwe_seen = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.hilo_we_o || bus.busy_o) hwe_seen++;
        end
        check("arst_no_we", hwe_seen, 0);
        $display("txn async reset abort done");

        // DIV with flush: never accepted
        step();
        drive(1'b1, F_DIV, 3'd0, 1'b1);
        check("flush_stall", {31'd0, bus.stall_o}, 32'd0);
        step();
        drive(1'b0, 6'd0, 3'd0, 1'b0);
        check("flush_busy", {31'd0, bus.busy_o}, 32'd0);
        check("flush_start", {31'd0, bus.md_start_o}, 32'd0);
        $display("txn DIV flush done");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_mc.md
Name: alu_ctrl_mc

Overview:
Next-generation ALU control for the pipelined MIPS core. It combinationally decodes ALUOp/funct into the 4-bit ALU code and the immediate-extend select, adding XOR/NOR/SLL/SRL/SLTU/ANDI and defaulted outputs for undefined codes. It also owns a multi-cycle sequencer for MULT/MULTU/DIV/DIVU that issues the HI/LO unit start, tracks latency, and raises pipeline stall on HI/LO hazards. It sits in EX, between the decoder's ALUOp output and the ALU / HI-LO unit.

Parameters:
ALUOP_W, 3, ALUOp width (codes 0..7 used).
MUL_LAT, 4, cycles in BUSY for MULT/MULTU (1..2^CNT_W-1).
DIV_LAT, 32, cycles in BUSY for DIV/DIVU (1..2^CNT_W-1).
CNT_W, 6, latency counter width.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous active-high reset.
valid_i  in  1  EX-stage instruction valid.
flush_i  in  1  EX-stage kill; blocks acceptance this cycle.
funct_i  in  6  R-type funct field.
aluop_i  in  ALUOP_W  decoder ALUOp.
aluctrl_o  out  4  ALU operation code.
sign_extend_o  out  1  1 = sign-extend immediate, 0 = zero-extend.
illegal_o  out  1  undefined R-type funct while valid_i.
hilo_rd_o  out  2  10 = MFHI, 01 = MFLO, 00 = neither.
md_start_o  out  1  one-cycle start pulse to the HI/LO unit.
md_op_o  out  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; held until next start.
busy_o  out  1  sequencer not IDLE.
hilo_we_o  out  1  one-cycle HI/LO write enable.
stall_o  out  1  hold IF/ID/EX this cycle.

Behaviour:
- Decode is combinational, 0 latency. ALU codes: AND 0, OR 1, NAND 2, NOR 3, ADDU 4, SUBU 5, SLT 6, EQUAL 7, SRA 8, SRAV 9, LUI 10, SLTU 11, SLL 12, SRL 13, XOR 14.
- ALUOp: 0 R-type (ext 0); 1 ADDI -> ADDU, ext 1; 2 SLTIU -> SLTU, ext 1; 3 BEQ -> SUBU, ext 1; 4 LUI -> LUI, ext 0; 5 ORI -> OR, ext 0; 6 BNE -> SUBU, ext 1; 7 ANDI -> AND, ext 0.
- R-type funct: 100001 ADDU, 100011 SUBU, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU, 000000 SLL, 000010 SRL, 000011 SRA, 000111 SRAV.
- 011000/011001/011010/011011 are MD ops (MULT/MULTU/DIV/DIVU); 010000 MFHI, 010010 MFLO. For these, aluctrl_o = ADDU.
- Any other funct: aluctrl_o = ADDU, illegal_o = valid_i. Every output is driven on every path; no latches.
- FSM states: IDLE, BUSY, DONE. busy_o = (state != IDLE).
- Accept: valid_i & !flush_i & MD op & state == IDLE. On that edge: state <- BUSY, cnt <- LAT-1 (MUL_LAT or DIV_LAT), md_op_o <- op. md_start_o = 1 for the first BUSY cycle only (registered).
- BUSY: cnt decrements each cycle. When cnt == 0, next state is DONE.
- DONE: hilo_we_o = 1 for exactly one cycle, then IDLE.
- Timing: accept in cycle 0 -> md_start_o in cycle 1, hilo_we_o in cycle LAT+1, IDLE in cycle LAT+2.
- stall_o = valid_i & !flush_i & (MD op | MFHI | MFLO) & busy_o. A stalled instruction is not accepted. The same instruction is re-presented, and is accepted in the first IDLE cycle.
- A non-HI/LO instruction never stalls while the sequencer is busy.
- flush_i does not affect an op already in flight.
- Reset (async, any state, including mid-op): state IDLE, cnt 0, md_start_o 0, md_op_o 00, hilo_we_o 0. An aborted op never produces hilo_we_o.

Test Plan:
- Decode sweep: every ALUOp 1..7, and every listed funct with ALUOp 0 -> aluctrl_o/sign_extend_o exactly per the tables. funct 111111 -> ADDU with illegal_o = 1.
- MULT with MUL_LAT = 4, accepted in cycle 0 -> md_start_o in cycle 1, md_op_o = 00, busy_o in cycles 1-5, hilo_we_o only in cycle 5, IDLE in cycle 6.
- DIVU accepted, then MFLO presented in cycle 2 -> stall_o = 1 in cycles 2-33 (DIV_LAT = 32). stall_o = 0 and hilo_rd_o = 01 in cycle 34.
- MULT in flight, ADDU presented every cycle -> stall_o stays 0, aluctrl_o = 4, sequence unaffected.
- MULT in flight, second DIV presented -> stalled until IDLE. DIV start pulse is the cycle after IDLE acceptance, md_op_o = 10.
- rst_i asserted mid-BUSY (cycle 3 of DIV) -> all registered outputs 0 immediately; no hilo_we_o afterwards. DIV with flush_i = 1 -> not accepted, busy_o stays 0.
